// File: rtl/reg_file_32x64.sv
// reg_file_32x64: 32 x DATA_WIDTH register file with two combinational read
// ports and one synchronous write port. Register 31 is hard-wired to zero.
// Optional build macro: REGFILE_BYPASS_EN adds write-through forwarding from
// the write port to each read port in the same cycle.

// Write-address decoder: one-hot select for the 31 stored registers.
module reg_file_dec (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [30:0] sel_c
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  // One-hot decode; address 31 has no storage so it selects nothing.
  always_comb begin
    sel_c = '0;
    if (en && (addr != ZERO_REG)) begin
      sel_c[addr] = 1'b1;
    end
  end

endmodule

// Enabled D flip-flop bank holding one register.
module reg_file_dff #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Load new data when selected, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Storage; synchronous reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// 32:1 read multiplexer; entry 31 is the constant-zero register.
module reg_file_rmux #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [30:0][WIDTH-1:0] regs,
  input  logic [4:0]             sel,
  output logic [WIDTH-1:0]       data_c
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  // Select the addressed register, zero for address 31.
  always_comb begin
    data_c = '0;
    if (sel != ZERO_REG) begin
      data_c = regs[sel];
    end
  end

endmodule

// Top level: decoder, 31 register banks and two read muxes.
module reg_file_32x64 #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int unsigned NUM_STORED = 31;
  localparam int unsigned NUM_READ   = 2;

  logic [NUM_STORED-1:0]                 wr_sel_c;
  logic [NUM_STORED-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_READ-1:0][4:0]              rd_addr;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]   rd_data_c;

  assign rd_addr[0] = ReadRegister1;
  assign rd_addr[1] = ReadRegister2;

  reg_file_dec u_dec (
    .en    (RegWrite),
    .addr  (WriteRegister),
    .sel_c (wr_sel_c)
  );

  for (genvar i = 0; i < NUM_STORED; i++) begin : g_reg
    reg_file_dff #(
      .WIDTH (DATA_WIDTH)
    ) u_dff (
      .clk   (clk),
      .reset (reset),
      .en    (wr_sel_c[i]),
      .d     (WriteData),
      .q     (regs_q[i])
    );
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] mux_data_c;
    logic [DATA_WIDTH-1:0] port_data_c;

    reg_file_rmux #(
      .WIDTH (DATA_WIDTH)
    ) u_rmux (
      .regs   (regs_q),
      .sel    (rd_addr[p]),
      .data_c (mux_data_c)
    );

`ifdef REGFILE_BYPASS_EN
    // Forward in-flight write data to a matching read address.
    always_comb begin
      port_data_c = mux_data_c;
      if (RegWrite && !reset && (WriteRegister == rd_addr[p]) &&
          (rd_addr[p] != 5'd31)) begin
        port_data_c = WriteData;
      end
    end
`else
    assign port_data_c = mux_data_c;
`endif

    assign rd_data_c[p] = port_data_c;
  end

  assign ReadData1 = rd_data_c[0];
  assign ReadData2 = rd_data_c[1];

endmodule

// File: tb/tb_reg_file_32x64.sv
// Randomized self-checking bench for reg_file_32x64 against an array model.
module tb_reg_file_32x64;

  localparam int unsigned DW = 64;
  localparam logic [63:0] PAT = 64'h0000010204080001;

  logic          clk;
  logic          reset;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [DW-1:0] WriteData;
  logic [4:0]    ReadRegister1;
  logic [4:0]    ReadRegister2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [DW-1:0] mdl [32];

  reg_file_32x64 #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural view of a read given the current input values.
  function automatic logic [DW-1:0] exp_read(input logic [4:0] a);
    if (a == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && !reset && (a == WriteRegister)) return WriteData;
`endif
    return mdl[a];
  endfunction

  task automatic check_reads(input string phase);
    check({phase, "_rd1"}, ReadData1, exp_read(ReadRegister1));
    check({phase, "_rd2"}, ReadData2, exp_read(ReadRegister2));
  endtask

  // Drive one cycle, check reads just before and just after the edge.
  task automatic apply(input logic r, input logic we, input logic [4:0] wa,
                       input logic [DW-1:0] wd, input logic [4:0] ra1,
                       input logic [4:0] ra2, input bit do_check);
    @(negedge clk);
    reset = r; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = ra1; ReadRegister2 = ra2;
    #1;
    if (do_check) check_reads("pre");
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 31; k++) mdl[k] = '0;
    end else if (we && wa != 5'd31) begin
      mdl[wa] = wd;
    end
    #1;
    if (do_check) check_reads("post");
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 1'b0, 5'd0, 64'(i), 5'(i), 5'(31 - i), 1'b1);
      check({tag, "_zero1"}, ReadData1, '0);
      check({tag, "_zero2"}, ReadData2, '0);
    end
  endtask

  initial begin
    reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    for (int k = 0; k < 32; k++) mdl[k] = '0;

    // Initial reset edge; contents undefined before it so no checks.
    apply(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0);
    sweep_zero("reset");

    // Write to register 31 is ignored.
    apply(1'b0, 1'b1, 5'd31, 64'h00000000000000A0, 5'd31, 5'd31, 1'b1);
    check("x31_rd1", ReadData1, '0);
    check("x31_rd2", ReadData2, '0);
    sweep_zero("after_x31");

    // Pattern fill: idle cycle then write cycle per register.
    for (int i = 0; i < 31; i++) begin
      logic [DW-1:0] pv;
      pv = 64'(i) * PAT;
      apply(1'b0, 1'b0, 5'(i), pv, 5'($urandom_range(0, 31)), 5'(i), 1'b1);
      check("fill_old", ReadData2, '0);
      apply(1'b0, 1'b1, 5'(i), pv, 5'($urandom_range(0, 31)), 5'(i), 1'b1);
      check("fill_new", ReadData2, pv);
    end
    apply(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd7, 1'b1);
    check("reg5_const", ReadData1, 64'h0000050A14280005);
    check("reg7_const", ReadData2, 64'h0000070E1C380007);

    // Retention sweep with changing write data and writes disabled.
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            5'(i - 1), 5'(i), 1'b1);
      check("ret_rd2", ReadData2, (i == 31) ? 64'd0 : 64'(i) * PAT);
    end

    // Write disabled to reg 7.
    apply(1'b0, 1'b0, 5'd7, 64'hFFFFFFFFFFFFFFFF, 5'd7, 5'd7, 1'b1);
    check("wdis_reg7", ReadData1, 64'd7 * PAT);

`ifdef REGFILE_BYPASS_EN
    // Forwarding visible before the edge.
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 64'hABCD;
    ReadRegister1 = 5'd4; ReadRegister2 = 5'd31; reset = 1'b0;
    #1;
    check("bypass_rd1", ReadData1, 64'hABCD);
    check("bypass_x31", ReadData2, '0);
    apply(1'b0, 1'b1, 5'd4, 64'hABCD, 5'd4, 5'd31, 1'b1);
`endif

    // Reset has priority over a simultaneous write.
    apply(1'b1, 1'b1, 5'd3, 64'h1234, 5'd3, 5'd4, 1'b1);
    check("rst_vs_wr", ReadData1, '0);
    sweep_zero("after_rst_wr");

    // Random traffic including occasional reset.
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 29) == 0), 1'($urandom), 5'($urandom),
            {$urandom, $urandom}, 5'($urandom), 5'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
